// File: rtl/pipelined_addsub.sv
// Pipelined WIDTH-bit adder/subtractor: one CHUNK-bit slice resolved per stage, carry registered
// between stages, valid/ready handshake with full backpressure and bubble collapsing.
module pipelined_addsub #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_sub,
   input  logic             in_cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             out_ovf
);

   localparam int unsigned STAGES = WIDTH / CHUNK;

   if (CHUNK == 0 || WIDTH % CHUNK != 0) begin : g_bad_chunk
      $error("WIDTH must be a non-zero multiple of CHUNK");
   end

   logic [STAGES-1:0] v_q, v_d;
   logic [STAGES-1:0] c_q, c_d;
   logic [STAGES:0]   adv;
   logic [WIDTH-1:0]  a_q   [STAGES];
   logic [WIDTH-1:0]  a_d   [STAGES];
   logic [WIDTH-1:0]  b_q   [STAGES];
   logic [WIDTH-1:0]  b_d   [STAGES];
   logic [WIDTH-1:0]  sum_q [STAGES];
   logic [WIDTH-1:0]  sum_d [STAGES];

   // Inputs seen by each stage: the ports for stage 0, the previous stage's registers otherwise.
   logic [STAGES-1:0] src_v;
   logic [STAGES-1:0] src_c;
   logic [WIDTH-1:0]  src_a   [STAGES];
   logic [WIDTH-1:0]  src_b   [STAGES];
   logic [WIDTH-1:0]  src_sum [STAGES];
   logic [CHUNK:0]    slice_res [STAGES];

   // A stage can take new content when it is empty or its occupant moves on this cycle.
   always_comb begin : p_ready
      adv = '0;
      adv[STAGES] = out_ready;
      for (int k = STAGES - 1; k >= 0; k--) begin
         adv[k] = ~v_q[k] | adv[k+1];
      end
   end

   assign in_ready = adv[0];

   always_comb begin : p_src
      src_v[0]   = in_valid;
      src_a[0]   = in_a;
      src_b[0]   = in_sub ? ~in_b : in_b;
      src_c[0]   = in_sub | in_cin;
      src_sum[0] = '0;
      for (int k = 1; k < STAGES; k++) begin
         src_v[k]   = v_q[k-1];
         src_a[k]   = a_q[k-1];
         src_b[k]   = b_q[k-1];
         src_c[k]   = c_q[k-1];
         src_sum[k] = sum_q[k-1];
      end
   end

   always_comb begin : p_stage
      for (int k = 0; k < STAGES; k++) begin
         slice_res[k] = {1'b0, src_a[k][k*CHUNK +: CHUNK]}
                      + {1'b0, src_b[k][k*CHUNK +: CHUNK]}
                      + {{CHUNK{1'b0}}, src_c[k]};
         v_d[k]   = adv[k] ? src_v[k] : v_q[k];
         a_d[k]   = a_q[k];
         b_d[k]   = b_q[k];
         sum_d[k] = sum_q[k];
         c_d[k]   = c_q[k];
         // Data only loads with a valid op, so idle/X operands never reach the outputs.
         if (adv[k] && src_v[k]) begin
            a_d[k]                      = src_a[k];
            b_d[k]                      = src_b[k];
            sum_d[k]                    = src_sum[k];
            sum_d[k][k*CHUNK +: CHUNK]  = slice_res[k][CHUNK-1:0];
            c_d[k]                      = slice_res[k][CHUNK];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v_q <= '0;
         c_q <= '0;
         for (int k = 0; k < STAGES; k++) begin
            a_q[k]   <= '0;
            b_q[k]   <= '0;
            sum_q[k] <= '0;
         end
      end else begin
         v_q <= v_d;
         c_q <= c_d;
         for (int k = 0; k < STAGES; k++) begin
            a_q[k]   <= a_d[k];
            b_q[k]   <= b_d[k];
            sum_q[k] <= sum_d[k];
         end
      end
   end

   assign out_valid = v_q[STAGES-1];
   assign out_sum   = sum_q[STAGES-1];
   assign out_cout  = c_q[STAGES-1];
   assign out_ovf   = (a_q[STAGES-1][WIDTH-1] == b_q[STAGES-1][WIDTH-1])
                    & (sum_q[STAGES-1][WIDTH-1] != a_q[STAGES-1][WIDTH-1]);

endmodule

// File: tb/tb_pipelined_addsub.sv
// Directed bench for pipelined_addsub: 4-stage instance (CHUNK=8) and 1-stage instance (CHUNK=32).
module tb_pipelined_addsub;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic        in_valid, in_ready, in_sub, in_cin, out_valid, out_ready, out_cout, out_ovf;
   logic [31:0] in_a, in_b, out_sum;
   logic        in_valid1, in_ready1, in_sub1, in_cin1, out_valid1, out_ready1, out_cout1, out_ovf1;
   logic [31:0] in_a1, in_b1, out_sum1;

   pipelined_addsub #(.WIDTH(32), .CHUNK(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
      .in_sub(in_sub), .in_cin(in_cin),
      .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
      .out_cout(out_cout), .out_ovf(out_ovf)
   );

   pipelined_addsub #(.WIDTH(32), .CHUNK(32)) dut1 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid1), .in_ready(in_ready1), .in_a(in_a1), .in_b(in_b1),
      .in_sub(in_sub1), .in_cin(in_cin1),
      .out_valid(out_valid1), .out_ready(out_ready1), .out_sum(out_sum1),
      .out_cout(out_cout1), .out_ovf(out_ovf1)
   );

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        sub;
      logic        cin;
      logic [31:0] sum;
      logic        cout;
      logic        ovf;
   } vec_t;

   vec_t vecs [10];
   int   n_chk  = 0;
   int   n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int lat;
      int n_in, n_out, stall_left, held;
      bit seen;

      rst_n = 1'b0;
      in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; in_cin = 1'b0; out_ready = 1'b1;
      in_valid1 = 1'b0; in_a1 = '0; in_b1 = '0; in_sub1 = 1'b0; in_cin1 = 1'b0;
      out_ready1 = 1'b1;

      // Reset held for 3 cycles
      repeat (3) begin
         step();
         chk("rst_out_valid", out_valid, 1'b0);
         chk("rst_out_sum", out_sum, 32'h0);
         chk("rst_out_cout", out_cout, 1'b0);
         chk("rst_out_ovf", out_ovf, 1'b0);
      end
      rst_n = 1'b1;
      #1;
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_in_ready1", in_ready1, 1'b1);

      vecs[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
      vecs[1] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1};
      vecs[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
      vecs[3] = '{32'd5,         32'd3,         1'b0, 1'b1, 32'd9,         1'b0, 1'b0};
      vecs[4] = '{32'd10,        32'd20,        1'b1, 1'b0, 32'hFFFF_FFF6, 1'b0, 1'b0};
      vecs[5] = '{32'd5,         32'd5,         1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
      vecs[6] = '{32'd5,         32'd5,         1'b1, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
      vecs[7] = '{32'h1234_5678, 32'h0F0F_0F0F, 1'b0, 1'b0, 32'h2143_6587, 1'b0, 1'b0};
      vecs[8] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0};
      vecs[9] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};

      step();
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1; in_a = vecs[i].a; in_b = vecs[i].b;
         in_sub = vecs[i].sub; in_cin = vecs[i].cin;
         #1;
         chk("vec_in_ready", in_ready, 1'b1);
         step();
         in_valid = 1'b0; in_a = 'x; in_b = 'x;
         lat = 1;
         while (!out_valid && lat < 20) begin
            step();
            lat++;
         end
         chk($sformatf("vec%0d_latency", i), lat, 4);
         chk($sformatf("vec%0d_sum", i), out_sum, vecs[i].sum);
         chk($sformatf("vec%0d_cout", i), out_cout, vecs[i].cout);
         chk($sformatf("vec%0d_ovf", i), out_ovf, vecs[i].ovf);
         step();
      end
      in_a = '0; in_b = '0; in_sub = 1'b0; in_cin = 1'b0;

      // Back-to-back with a 6-cycle stall starting at the first result
      n_in = 0; n_out = 0; stall_left = 0; seen = 1'b0;
      for (int cyc = 0; cyc < 60 && n_out < 8; cyc++) begin
         if (!seen && out_valid) begin
            seen = 1'b1;
            stall_left = 6;
         end
         out_ready = (stall_left == 0);
         in_valid = (n_in < 8);
         in_a = n_in;
         in_b = 32'h10 * n_in;
         #1;
         held = n_in - n_out;
         chk("bp_in_ready", in_ready, (out_ready || held < 4));
         if (!out_ready) begin
            chk("bp_stall_valid", out_valid, 1'b1);
            chk("bp_stall_sum", out_sum, 32'h11 * n_out);
         end
         if (seen && stall_left == 0) chk("bp_stream_valid", out_valid, 1'b1);
         if (out_valid && out_ready) begin
            chk("bp_sum", out_sum, 32'h11 * n_out);
            n_out++;
         end
         if (in_valid && in_ready) n_in++;
         if (stall_left > 0) stall_left--;
         step();
      end
      chk("bp_out_count", n_out, 8);
      chk("bp_in_count", n_in, 8);
      in_valid = 1'b0;
      step();
      chk("bp_drained", out_valid, 1'b0);

      // Reset mid-flight
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_a = i + 1; in_b = 32'd1;
         step();
      end
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 20) begin
         step();
         lat++;
      end
      chk("mid_valid_before_rst", out_valid, 1'b1);
      #3 rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", out_valid, 1'b0);
      chk("mid_rst_sum", out_sum, 32'h0);
      step();
      step();
      #2 rst_n = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         chk("post_rst_no_valid", out_valid, 1'b0);
      end
      chk("post_rst_in_ready", in_ready, 1'b1);

      // Single-stage instance: latency and throughput
      in_valid1 = 1'b1; in_a1 = 32'd10; in_b1 = 32'd20; in_sub1 = 1'b1; in_cin1 = 1'b0;
      step();
      in_valid1 = 1'b0;
      chk("s1_latency_valid", out_valid1, 1'b1);
      chk("s1_sum", out_sum1, 32'hFFFF_FFF6);
      chk("s1_cout", out_cout1, 1'b0);
      chk("s1_ovf", out_ovf1, 1'b0);
      step();
      chk("s1_consumed", out_valid1, 1'b0);
      in_sub1 = 1'b0;
      for (int j = 0; j < 6; j++) begin
         in_valid1 = (j < 5);
         in_a1 = 100 + j;
         in_b1 = j;
         #1;
         if (j < 5) chk("s1_tp_in_ready", in_ready1, 1'b1);
         if (j >= 1) begin
            chk("s1_tp_valid", out_valid1, 1'b1);
            chk("s1_tp_sum", out_sum1, 100 + 2 * (j - 1));
         end
         step();
      end
      in_valid1 = 1'b0;
      chk("s1_tp_drained", out_valid1, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
